// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage.
//   SIZE_*      : access size encodings carried on mem_size_mem
//   mem_state_t : MEM stage bus FSM states
//   BYTE_LANES  : byte lanes in a 32-bit data word
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int BYTE_LANES = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it. Word loads pass through unchanged.
//   i: rdata     raw bus read word
//   i: addr      byte offset within the word
//   i: size      access size (SIZE_BYTE/HALF/WORD; 3 behaves as word)
//   i: is_signed sign-extend byte/half
//   o: data      aligned, extended result
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Equivalent to taking the low bits of rdata >> (8*addr). Halves are only
  // issued at offsets 0 or 2, so addr[1] alone selects the half.
  assign w_byte = rdata[{addr, 3'b000} +: 8];
  assign w_half = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (size)
      SIZE_BYTE: data = is_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      SIZE_HALF: data = is_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/memory.sv
// MEM stage of the 5-stage MIPS pipeline.
// Drives the data-memory req/ack bus (byte enables, lane-replicated store
// data), aligns load data, stalls upstream while an access is outstanding,
// and registers all signals handed to write-back.
//   clk, rst (sync, active high)
//   ex->mem : valid_mem, alu_data_mem, store_data_mem, mem_read_mem,
//             mem_write_mem, mem_size_mem, mem_signed_mem, reg_d_we_mem,
//             reg_d_addr_mem, reg_d_data_sel_mem
//   bus     : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata (out),
//             dmem_rdata, dmem_ack (in)
//   control : stall_mem
//   mem->wb : addr_err_wb, alu_data_wb, mem_data_wb, reg_d_we_wb,
//             reg_d_addr_wb, reg_d_data_sel_wb
module memory
  import mips_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_mem,
  input  logic [WORD_SIZE-1:0]   alu_data_mem,
  input  logic [WORD_SIZE-1:0]   store_data_mem,
  input  logic                   mem_read_mem,
  input  logic                   mem_write_mem,
  input  logic [1:0]             mem_size_mem,
  input  logic                   mem_signed_mem,
  input  logic                   reg_d_we_mem,
  input  logic [ADDR_SIZE-1:0]   reg_d_addr_mem,
  input  logic                   reg_d_data_sel_mem,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [WORD_SIZE-1:0]   dmem_addr,
  output logic [WORD_SIZE/8-1:0] dmem_be,
  output logic [WORD_SIZE-1:0]   dmem_wdata,
  input  logic [WORD_SIZE-1:0]   dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   stall_mem,
  output logic                   addr_err_wb,
  output logic [WORD_SIZE-1:0]   alu_data_wb,
  output logic [WORD_SIZE-1:0]   mem_data_wb,
  output logic                   reg_d_we_wb,
  output logic [ADDR_SIZE-1:0]   reg_d_addr_wb,
  output logic                   reg_d_data_sel_wb
);

  mem_state_t r_state;

  logic [1:0]            w_ofs;
  logic                  w_is_byte;
  logic                  w_is_half;
  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_access;
  logic                  w_is_load;
  logic [BYTE_LANES-1:0] w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_load_data;

  logic                  r_addr_err_wb;
  logic [WORD_SIZE-1:0]  r_alu_data_wb;
  logic [WORD_SIZE-1:0]  r_mem_data_wb;
  logic                  r_reg_d_we_wb;
  logic [ADDR_SIZE-1:0]  r_reg_d_addr_wb;
  logic                  r_reg_d_data_sel_wb;

  assign w_ofs     = alu_data_mem[1:0];
  assign w_is_byte = (mem_size_mem == SIZE_BYTE);
  assign w_is_half = (mem_size_mem == SIZE_HALF);
  assign w_mem_op  = valid_mem & (mem_read_mem | mem_write_mem);

  // Anything that is neither byte nor half (including encoding 3) is a word.
  assign w_misaligned = w_mem_op &
                        ((w_is_half & w_ofs[0]) |
                         (~w_is_byte & ~w_is_half & (w_ofs != 2'd0)));
  assign w_access  = w_mem_op & ~w_misaligned;
  // Read+write together is treated as a write, so it is not a load.
  assign w_is_load = w_access & mem_read_mem & ~mem_write_mem;

  always_comb begin
    w_be    = 4'hF;
    w_wdata = store_data_mem;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_ofs;
      w_wdata = {4{store_data_mem[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << w_ofs;
      w_wdata = {2{store_data_mem[15:0]}};
    end
  end

  // Upstream holds the MEM inputs while stalled, so the bus fields derived
  // from them stay stable through WAIT without extra holding registers.
  assign dmem_req   = ~rst & ((r_state == ST_WAIT) | w_access);
  assign dmem_we    = dmem_req & mem_write_mem;
  assign dmem_addr  = {alu_data_mem[WORD_SIZE-1:2], 2'b00};
  assign dmem_be    = w_be;
  assign dmem_wdata = w_wdata;
  assign stall_mem  = dmem_req & ~dmem_ack;

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr      (w_ofs),
    .size      (mem_size_mem),
    .is_signed (mem_signed_mem),
    .data      (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_access && !dmem_ack) r_state <= ST_WAIT;
        ST_WAIT: if (dmem_ack)              r_state <= ST_IDLE;
        default:                            r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err_wb       <= 1'b0;
      r_alu_data_wb       <= '0;
      r_mem_data_wb       <= '0;
      r_reg_d_we_wb       <= 1'b0;
      r_reg_d_addr_wb     <= '0;
      r_reg_d_data_sel_wb <= 1'b0;
    end else if (stall_mem) begin
      // Bubble: only the side-effecting flags are cleared.
      r_addr_err_wb <= 1'b0;
      r_reg_d_we_wb <= 1'b0;
    end else begin
      r_addr_err_wb       <= w_misaligned;
      r_alu_data_wb       <= alu_data_mem;
      r_mem_data_wb       <= w_is_load ? w_load_data : '0;
      r_reg_d_we_wb       <= valid_mem & reg_d_we_mem & ~w_misaligned;
      r_reg_d_addr_wb     <= reg_d_addr_mem;
      r_reg_d_data_sel_wb <= reg_d_data_sel_mem;
    end
  end

  assign addr_err_wb       = r_addr_err_wb;
  assign alu_data_wb       = r_alu_data_wb;
  assign mem_data_wb       = r_mem_data_wb;
  assign reg_d_we_wb       = r_reg_d_we_wb;
  assign reg_d_addr_wb     = r_reg_d_addr_wb;
  assign reg_d_data_sel_wb = r_reg_d_data_sel_wb;

endmodule

// File: tb/tb_memory.sv
module tb_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem;
  logic [31:0] alu_data_mem;
  logic [31:0] store_data_mem;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [1:0]  mem_size_mem;
  logic        mem_signed_mem;
  logic        reg_d_we_mem;
  logic [4:0]  reg_d_addr_mem;
  logic        reg_d_data_sel_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_mem;
  logic        addr_err_wb;
  logic [31:0] alu_data_wb;
  logic [31:0] mem_data_wb;
  logic        reg_d_we_wb;
  logic [4:0]  reg_d_addr_wb;
  logic        reg_d_data_sel_wb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        we;
    logic [4:0]  rd;
    logic        sel;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  memory #(.ADDR_SIZE(5), .WORD_SIZE(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_mem          (valid_mem),
    .alu_data_mem       (alu_data_mem),
    .store_data_mem     (store_data_mem),
    .mem_read_mem       (mem_read_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_size_mem       (mem_size_mem),
    .mem_signed_mem     (mem_signed_mem),
    .reg_d_we_mem       (reg_d_we_mem),
    .reg_d_addr_mem     (reg_d_addr_mem),
    .reg_d_data_sel_mem (reg_d_data_sel_mem),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack),
    .stall_mem          (stall_mem),
    .addr_err_wb        (addr_err_wb),
    .alu_data_wb        (alu_data_wb),
    .mem_data_wb        (mem_data_wb),
    .reg_d_we_wb        (reg_d_we_wb),
    .reg_d_addr_wb      (reg_d_addr_wb),
    .reg_d_data_sel_wb  (reg_d_data_sel_wb)
  );

  // Bus memory model: combinational read, byte-enabled write on ack.
  assign dmem_rdata = mem[dmem_addr[11:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h040] <= 32'h80FF_0000;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (dmem_be[b]) mem[dmem_addr[11:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] st,
                       input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic we, input logic [4:0] rdst,
                       input logic sel);
    valid_mem          = v;
    alu_data_mem       = alu;
    store_data_mem     = st;
    mem_read_mem       = rd;
    mem_write_mem      = wr;
    mem_size_mem       = size;
    mem_signed_mem     = sgn;
    reg_d_we_mem       = we;
    reg_d_addr_mem     = rdst;
    reg_d_data_sel_mem = sel;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] mdata,
                      input logic we, input logic [4:0] rdst, input logic sel,
                      input logic err);
    exp_t e;
    e.tag = tag; e.alu = alu; e.mdata = mdata; e.we = we;
    e.rd = rdst; e.sel = sel; e.err = err;
    sb.push_back(e);
  endtask

  // Advance to the next edge and compare the WB outputs with the oldest
  // expected entry.
  task automatic wb_check();
    exp_t e;
    @(posedge clk); #1;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_alu"},   alu_data_wb,              e.alu);
      chk({e.tag, "_mdata"}, mem_data_wb,              e.mdata);
      chk({e.tag, "_we"},    32'(reg_d_we_wb),         32'(e.we));
      chk({e.tag, "_rd"},    32'(reg_d_addr_wb),       32'(e.rd));
      chk({e.tag, "_sel"},   32'(reg_d_data_sel_wb),   32'(e.sel));
      chk({e.tag, "_err"},   32'(addr_err_wb),         32'(e.err));
    end
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(reg_d_we_wb), 32'd0);
    chk("rst_alu",   alu_data_wb,      32'd0);
    chk("rst_stall", 32'(stall_mem),   32'd0);
    chk("rst_req",   32'(dmem_req),    32'd0);
    rst = 1'b0;

    // 1: plain ALU op
    dmem_ack = 1'b1;
    drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5, 1'b0);
    #4;
    chk("alu_req",   32'(dmem_req),  32'd0);
    chk("alu_stall", 32'(stall_mem), 32'd0);
    push("alu", 32'h1234, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0);
    wb_check();

    // 2: lb / lbu at 0x103, zero-wait
    drive(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd8, 1'b1);
    #4;
    chk("lb_addr",  dmem_addr,       32'h100);
    chk("lb_be",    32'(dmem_be),    32'h8);
    chk("lb_req",   32'(dmem_req),   32'd1);
    chk("lb_stall", 32'(stall_mem),  32'd0);
    push("lb", 32'h103, 32'hFFFF_FF80, 1'b1, 5'd8, 1'b1, 1'b0);
    wb_check();
    drive(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    push("lbu", 32'h103, 32'h0000_0080, 1'b1, 5'd9, 1'b1, 1'b0);
    wb_check();

    // lh / lhu at 0x102 (upper half of the same word)
    drive(1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd10, 1'b1);
    push("lh", 32'h102, 32'hFFFF_80FF, 1'b1, 5'd10, 1'b1, 1'b0);
    wb_check();
    drive(1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd11, 1'b1);
    push("lhu", 32'h102, 32'h0000_80FF, 1'b1, 5'd11, 1'b1, 1'b0);
    wb_check();

    // 3: sh at 0x202 with 3 wait cycles
    dmem_ack = 1'b0;
    drive(1'b1, 32'h202, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("sh_stall", 32'(stall_mem), 32'd1);
      chk("sh_req",   32'(dmem_req),  32'd1);
      chk("sh_we",    32'(dmem_we),   32'd1);
      chk("sh_addr",  dmem_addr,      32'h200);
      chk("sh_be",    32'(dmem_be),   32'hC);
      chk("sh_wdata", dmem_wdata,     32'hBEEF_BEEF);
      @(posedge clk); #1;
      chk("sh_bubble_we",  32'(reg_d_we_wb), 32'd0);
      chk("sh_bubble_err", 32'(addr_err_wb), 32'd0);
    end
    dmem_ack = 1'b1;
    #4;
    chk("sh_ack_stall", 32'(stall_mem), 32'd0);
    chk("sh_ack_req",   32'(dmem_req),  32'd1);
    push("sh", 32'h202, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_check();
    idle();
    chk("sh_mem", mem[10'h080], 32'hBEEF_0000);

    // 4: misaligned lw at 0x301, misaligned lh at 0x201
    drive(1'b1, 32'h301, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd3, 1'b1);
    #4;
    chk("lw_mis_req",   32'(dmem_req),  32'd0);
    chk("lw_mis_stall", 32'(stall_mem), 32'd0);
    push("lw_mis", 32'h301, 32'h0, 1'b0, 5'd3, 1'b1, 1'b1);
    wb_check();
    drive(1'b1, 32'h201, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd4, 1'b1);
    #4;
    chk("lh_mis_req", 32'(dmem_req), 32'd0);
    push("lh_mis", 32'h201, 32'h0, 1'b0, 5'd4, 1'b1, 1'b1);
    wb_check();

    // 5: lh with ack withheld, reset in the 2nd WAIT cycle
    dmem_ack = 1'b0;
    drive(1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd7, 1'b1);
    #4;
    chk("rw_req0", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    #4;
    chk("rw_wait1_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    chk("rw_rst_req",   32'(dmem_req),  32'd0);
    chk("rw_rst_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("rw_wb_we",    32'(reg_d_we_wb),       32'd0);
    chk("rw_wb_err",   32'(addr_err_wb),       32'd0);
    chk("rw_wb_alu",   alu_data_wb,            32'd0);
    chk("rw_wb_mdata", mem_data_wb,            32'd0);
    chk("rw_wb_rd",    32'(reg_d_addr_wb),     32'd0);
    chk("rw_wb_sel",   32'(reg_d_data_sel_wb), 32'd0);
    #4;
    chk("rw_idle_req",   32'(dmem_req),  32'd0);
    chk("rw_idle_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;

    // 6: back-to-back sw then lw at 0x400, zero-wait
    dmem_ack = 1'b1;
    drive(1'b1, 32'h400, 32'h1234_5678, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    #4;
    chk("sw_stall", 32'(stall_mem), 32'd0);
    chk("sw_be",    32'(dmem_be),   32'hF);
    push("sw", 32'h400, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_check();
    drive(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd12, 1'b1);
    #4;
    chk("lw_stall", 32'(stall_mem), 32'd0);
    push("lw", 32'h400, 32'h1234_5678, 1'b1, 5'd12, 1'b1, 1'b0);
    wb_check();
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- MEM stage of the 5-stage MIPS pipeline, between execute (ex->mem signals) and write-back (mem->wb signals).
- Drives the data-memory bus with a req/ack handshake and generates byte enables and lane-replicated store data.
- Aligns and sign/zero-extends load data.
- Registers all mem->wb signals. While a memory access is outstanding it stalls the upstream stages.

Parameters:
- ADDR_SIZE, 5, register-file address width.
- WORD_SIZE, 32, datapath width; only 32 is supported. Byte lanes = WORD_SIZE/8.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
valid_mem  in  1  instruction in MEM is valid
alu_data_mem  in  WORD_SIZE  ALU result / effective address
store_data_mem  in  WORD_SIZE  rt value for stores
mem_read_mem  in  1  load
mem_write_mem  in  1  store
mem_size_mem  in  2  0=byte, 1=half, 2=word (3 is illegal, treated as word)
mem_signed_mem  in  1  sign-extend load (lb/lh)
reg_d_we_mem  in  1  register write enable
reg_d_addr_mem  in  ADDR_SIZE  destination register
reg_d_data_sel_mem  in  1  1 = write-back takes memory data
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  WORD_SIZE  word-aligned address {alu[31:2],2'b00}
dmem_be  out  WORD_SIZE/8  byte enables
dmem_wdata  out  WORD_SIZE  lane-replicated store data
dmem_rdata  in  WORD_SIZE  read data, valid with dmem_ack
dmem_ack  in  1  access complete
stall_mem  out  1  freeze IF/ID/EX and hold MEM inputs
addr_err_wb  out  1  misaligned access flag, registered
alu_data_wb  out  WORD_SIZE  registered to WB
mem_data_wb  out  WORD_SIZE  aligned and extended load data, registered
reg_d_we_wb  out  1  registered
reg_d_addr_wb  out  ADDR_SIZE  registered
reg_d_data_sel_wb  out  1  registered

Behaviour:
- Access is defined as: valid_mem & (mem_read_mem | mem_write_mem) & aligned.
- If mem_read_mem and mem_write_mem are both set, the access is a write.
- Alignment rules:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - Misaligned: no bus request; next cycle addr_err_wb=1 and reg_d_we_wb=0.
- Byte enables (little-endian):
  - byte: be = 1<<addr[1:0]
  - half: be = 4'b0011<<addr[1:0]
  - word: be = 4'hF
- Store data: byte -> {4{st[7:0]}}, half -> {2{st[15:0]}}, word -> st.
- Load data:
  - Extract lane = rdata >> (8*addr[1:0]).
  - Then sign- or zero-extend the byte or half per mem_signed_mem. Word loads are passed through unchanged.
- FSM has two states, IDLE and WAIT.
  - IDLE: if access, then dmem_req=1 (combinational). If dmem_ack is high in the same cycle, the access completes (zero-wait); otherwise go to WAIT.
  - WAIT: dmem_req=1 with address, be, wdata and we held stable. On dmem_ack, go to IDLE.
  - dmem_req never drops before ack.
- stall_mem = dmem_req & ~dmem_ack.
  - Upstream holds the MEM inputs stable while stall_mem is high.
- WB register, every cycle:
  - If stall_mem: insert a bubble. reg_d_we_wb=0 and addr_err_wb=0; the other wb outputs are don't-care and hold their values.
  - Else: capture the inputs. mem_data_wb gets the aligned load (0 when not a load). reg_d_we_wb = valid_mem & reg_d_we_mem & ~misaligned.
- Latency: 1 cycle from MEM inputs to WB outputs with zero-wait memory; 1+N cycles with N wait cycles.
- Non-memory instructions never stall.
- dmem_ack while dmem_req=0 is ignored.
- Reset:
  - State becomes IDLE and all wb outputs become 0.
  - dmem_req is gated by ~rst, so it is 0 during the reset cycle, including when reset arrives mid-WAIT. The pending access is abandoned.
  - stall_mem is 0 during reset.

Decomposition:
- Shared package mips_pkg holds:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2
  - MEM FSM state encoding (IDLE, WAIT)
  - BYTE_LANES constant
- Sub-module load_align (combinational): inputs rdata, addr[1:0], size, signed; output extended word.
- The FSM, store formatting and WB register live in memory.

Test Plan:
1. ALU op, valid_mem=1, reg_d_we_mem=1, alu=0x1234, addr_d=5 -> next cycle alu_data_wb=0x1234, reg_d_we_wb=1, reg_d_addr_wb=5; dmem_req=0, stall_mem=0.
2. lb, addr=0x103, rdata=0x80FF_0000, ack same cycle -> dmem_addr=0x100, be=4'b1000, mem_data_wb=0xFFFF_FF80. Repeat as lbu -> 0x0000_0080.
3. sh, addr=0x202, st=0xAAAA_BEEF, ack after 3 wait cycles -> stall_mem=1 for exactly 3 cycles; be=4'b1100 and wdata=0xBEEF_BEEF held stable throughout; reg_d_we_wb=0 during the stall.
4. lw, addr=0x301 -> no dmem_req; next cycle addr_err_wb=1, reg_d_we_wb=0.
5. lh with ack withheld, rst asserted in the 2nd WAIT cycle -> dmem_req=0 in the reset cycle; after reset, state is IDLE, all wb outputs are 0, stall_mem=0.
6. Back-to-back sw 0x400 then lw 0x400, zero-wait memory -> no stall cycles; the lw returns the stored word in mem_data_wb.
